// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code receive checker.
//   state_t      : checker FSM encoding (HUNT / CONFIRM / LOCKED)
//   DEF_*        : default parameter values used by the checker and its bench
//   gray2bin()   : reference Gray->binary conversion for up to 32-bit codes
package gray_pkg;

   typedef enum logic [1:0] {
      ST_HUNT    = 2'd0,
      ST_CONFIRM = 2'd1,
      ST_LOCKED  = 2'd2
   } state_t;

   localparam int DEF_W      = 3;
   localparam int DEF_LOCK_N = 2;
   localparam int DEF_LOSS_N = 2;
   localparam int DEF_CNT_W  = 8;

   // Binary bit i is the XOR of all Gray bits at or above i, which is the
   // XOR of the code shifted right by 0..w-1 positions.
   function automatic logic [31:0] gray2bin(input logic [31:0] g, input int w);
      logic [31:0] mask;
      logic [31:0] gm;
      logic [31:0] b;
      mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      gm   = g & mask;
      b    = '0;
      for (int k = 0; k < 32; k++) begin
         if (k < w) b = b ^ (gm >> k);
      end
      return b & mask;
   endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Purely combinational W-bit Gray to binary converter.
// Ports:
//   code : Gray-coded input
//   bin  : binary equivalent
module gray_to_bin #(
   parameter int W = 3
) (
   input  logic [W-1:0] code,
   output logic [W-1:0] bin
);

   // Each binary bit is the reduction XOR of the Gray bits from the MSB
   // down to that position; written per bit so no bit depends on another
   // bit of the same vector.
   for (genvar i = 0; i < W; i++) begin : g_bit
      assign bin[i] = ^code[W-1:i];
   end

endmodule

// File: rtl/gray_rx_checker.sv
// Receive-side checker for a Gray-coded counter link.
// Every strobed sample is converted to binary and compared against the
// modulo-2^W successor of the previous sample. An FSM acquires lock after
// LOCK_N consecutive good steps and drops it after LOSS_N consecutive bad
// steps while locked. Bad steps while locked pulse err and bump a
// saturating counter.
//
// State table:
//   state      | meaning
//   ST_HUNT    | no reference yet; next sample seeds the reference
//   ST_CONFIRM | counting consecutive good steps toward lock
//   ST_LOCKED  | link trusted; bad steps are reported and counted
//
// Ports:
//   clk       : system clock, rising edge
//   reset     : synchronous active-low reset
//   valid     : sample code this cycle
//   code      : incoming W-bit Gray code
//   bin       : registered binary of last sampled code
//   bin_valid : one-cycle pulse, bin updated
//   locked    : FSM is in LOCKED
//   err       : one-cycle pulse on a bad step while locked
//   err_count : saturating count of err pulses
module gray_rx_checker
   import gray_pkg::*;
#(
   parameter int W      = DEF_W,
   parameter int LOCK_N = DEF_LOCK_N,
   parameter int LOSS_N = DEF_LOSS_N,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid,
   input  logic [W-1:0]     code,
   output logic [W-1:0]     bin,
   output logic             bin_valid,
   output logic             locked,
   output logic             err,
   output logic [CNT_W-1:0] err_count
);

   localparam int GW = $clog2(LOCK_N + 1);
   localparam int MW = $clog2(LOSS_N + 1);
   localparam logic [GW-1:0] GOOD_TGT = GW'(LOCK_N);
   localparam logic [MW-1:0] MISS_TGT = MW'(LOSS_N);

   state_t          state_q, state_d;
   logic [GW-1:0]   good_q, good_d;
   logic [MW-1:0]   miss_q, miss_d;
   logic [W-1:0]    ref_q, ref_d;
   logic [W-1:0]    bin_d;
   logic            bin_valid_d;
   logic            err_d;
   logic [CNT_W-1:0] cnt_d;

   logic [W-1:0]    conv;
   logic [W-1:0]    ref_next;
   logic            good_step;
   logic [GW-1:0]   good_inc;
   logic [MW-1:0]   miss_inc;

   gray_to_bin #(.W(W)) u_conv (
      .code (code),
      .bin  (conv)
   );

   // Forward successor wraps naturally at W bits (all-ones -> 0 is good).
   assign ref_next  = ref_q + 1'b1;
   assign good_step = (conv == ref_next);
   assign good_inc  = good_q + 1'b1;
   assign miss_inc  = miss_q + 1'b1;

   assign locked = (state_q == ST_LOCKED);

   always_comb begin
      state_d     = state_q;
      good_d      = good_q;
      miss_d      = miss_q;
      ref_d       = ref_q;
      bin_d       = bin;
      bin_valid_d = 1'b0;
      err_d       = 1'b0;
      cnt_d       = err_count;

      if (valid) begin
         bin_d       = conv;
         bin_valid_d = 1'b1;
         // Always resync to the received value so one glitch costs a
         // single bad step rather than a run of them.
         ref_d       = conv;

         unique case (state_q)
            ST_HUNT: begin
               good_d  = '0;
               state_d = ST_CONFIRM;
            end

            ST_CONFIRM: begin
               if (good_step) begin
                  if (good_inc == GOOD_TGT) begin
                     state_d = ST_LOCKED;
                     good_d  = '0;
                     miss_d  = '0;
                  end else begin
                     good_d = good_inc;
                  end
               end else begin
                  good_d = '0;
               end
            end

            ST_LOCKED: begin
               if (good_step) begin
                  miss_d = '0;
               end else begin
                  err_d = 1'b1;
                  if (err_count != {CNT_W{1'b1}}) cnt_d = err_count + 1'b1;
                  if (miss_inc == MISS_TGT) begin
                     state_d = ST_HUNT;
                     good_d  = '0;
                     miss_d  = '0;
                  end else begin
                     miss_d = miss_inc;
                  end
               end
            end

            default: begin
               state_d = ST_HUNT;
               good_d  = '0;
               miss_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_HUNT;
         good_q    <= '0;
         miss_q    <= '0;
         ref_q     <= '0;
         bin       <= '0;
         bin_valid <= 1'b0;
         err       <= 1'b0;
         err_count <= '0;
      end else begin
         state_q   <= state_d;
         good_q    <= good_d;
         miss_q    <= miss_d;
         ref_q     <= ref_d;
         bin       <= bin_d;
         bin_valid <= bin_valid_d;
         err       <= err_d;
         err_count <= cnt_d;
      end
   end

endmodule

// File: tb/tb_gray_rx_checker.sv
module tb_gray_rx_checker;
   import gray_pkg::*;

   localparam int W     = 3;
   localparam int CNT_W = 8;

   logic             clk;
   logic             reset;
   logic             valid;
   logic [W-1:0]     code;
   logic [W-1:0]     bin;
   logic             bin_valid;
   logic             locked;
   logic             err;
   logic [CNT_W-1:0] err_count;

   gray_rx_checker #(
      .W(W), .LOCK_N(2), .LOSS_N(2), .CNT_W(CNT_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .valid     (valid),
      .code      (code),
      .bin       (bin),
      .bin_valid (bin_valid),
      .locked    (locked),
      .err       (err),
      .err_count (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0]     bin;
      logic             err;
      logic             lk;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0]     hold_bin = '0;
   logic             hold_lk  = 1'b0;
   logic [CNT_W-1:0] hold_cnt = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops one expectation per bin_valid pulse; between pulses the
   // outputs must hold and err must stay low.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (bin_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_bin_valid", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("bin", 32'(bin), 32'(e.bin));
               check("err", 32'(err), 32'(e.err));
               check("locked", 32'(locked), 32'(e.lk));
               check("err_count", 32'(err_count), 32'(e.cnt));
               hold_bin = e.bin;
               hold_lk  = e.lk;
               hold_cnt = e.cnt;
            end
         end else begin
            check("bin_valid_idle", 32'(bin_valid), 32'd0);
            check("err_idle", 32'(err), 32'd0);
            check("bin_hold", 32'(bin), 32'(hold_bin));
            check("locked_hold", 32'(locked), 32'(hold_lk));
            check("cnt_hold", 32'(err_count), 32'(hold_cnt));
         end
      end
   end

   function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Drive one cycle; called #1 after a rising edge.
   task automatic drive(input logic v, input logic [W-1:0] c,
                        input logic [W-1:0] eb, input logic ee,
                        input logic el, input logic [CNT_W-1:0] ec);
      exp_t e;
      valid = v;
      code  = c;
      if (v) begin
         e.bin = eb; e.err = ee; e.lk = el; e.cnt = ec;
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
   endtask

   task automatic gap();
      drive(1'b0, 3'b000, '0, 1'b0, 1'b0, '0);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b0;
      valid = 1'b1;
      code  = 3'b011;
      repeat (n) @(posedge clk);
      #1;
      check("rst_bin", 32'(bin), 32'd0);
      check("rst_bin_valid", 32'(bin_valid), 32'd0);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
      hold_bin = '0;
      hold_lk  = 1'b0;
      hold_cnt = '0;
      valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin : stim
      logic [W-1:0]     r;
      logic [CNT_W-1:0] c;
      reset = 1'b0;
      valid = 1'b0;
      code  = '0;
      @(posedge clk); #1;

      do_reset(2);

      // Acquire: 000, 001, 011 -> lock after third sample
      drive(1'b1, 3'b000, 3'd0, 1'b0, 1'b0, 8'd0);
      drive(1'b1, 3'b001, 3'd1, 1'b0, 1'b0, 8'd0);
      drive(1'b1, 3'b011, 3'd2, 1'b0, 1'b1, 8'd0);

      // Wrap with gaps
      drive(1'b1, 3'b010, 3'd3, 1'b0, 1'b1, 8'd0);
      gap();
      drive(1'b1, 3'b110, 3'd4, 1'b0, 1'b1, 8'd0);
      gap(); gap();
      drive(1'b1, 3'b111, 3'd5, 1'b0, 1'b1, 8'd0);
      drive(1'b1, 3'b101, 3'd6, 1'b0, 1'b1, 8'd0);
      gap();
      drive(1'b1, 3'b100, 3'd7, 1'b0, 1'b1, 8'd0);
      drive(1'b1, 3'b000, 3'd0, 1'b0, 1'b1, 8'd0);
      gap();

      // Single error: get to 011, skip to 110, then good 111
      drive(1'b1, 3'b001, 3'd1, 1'b0, 1'b1, 8'd0);
      drive(1'b1, 3'b011, 3'd2, 1'b0, 1'b1, 8'd0);
      drive(1'b1, 3'b110, 3'd4, 1'b1, 1'b1, 8'd1);
      drive(1'b1, 3'b111, 3'd5, 1'b0, 1'b1, 8'd1);

      // Loss of lock: advance to 001, repeat, then step backward
      drive(1'b1, 3'b101, 3'd6, 1'b0, 1'b1, 8'd1);
      drive(1'b1, 3'b100, 3'd7, 1'b0, 1'b1, 8'd1);
      drive(1'b1, 3'b000, 3'd0, 1'b0, 1'b1, 8'd1);
      drive(1'b1, 3'b001, 3'd1, 1'b0, 1'b1, 8'd1);
      drive(1'b1, 3'b001, 3'd1, 1'b1, 1'b1, 8'd2);
      drive(1'b1, 3'b000, 3'd0, 1'b1, 1'b0, 8'd3);
      gap();

      // Re-acquire, including a bad step in CONFIRM (silent, resets good count)
      drive(1'b1, 3'b001, 3'd1, 1'b0, 1'b0, 8'd3);
      drive(1'b1, 3'b001, 3'd1, 1'b0, 1'b0, 8'd3);
      drive(1'b1, 3'b011, 3'd2, 1'b0, 1'b0, 8'd3);
      drive(1'b1, 3'b010, 3'd3, 1'b0, 1'b1, 8'd3);

      // Saturation: 150 rounds of two repeats (loss) plus re-acquire
      r = 3'd3;
      c = 8'd3;
      for (int i = 0; i < 150; i++) begin
         if (c != 8'd255) c = c + 8'd1;
         drive(1'b1, b2g(r), r, 1'b1, 1'b1, c);
         if (c != 8'd255) c = c + 8'd1;
         drive(1'b1, b2g(r), r, 1'b1, 1'b0, c);
         drive(1'b1, b2g(r + 3'd1), r + 3'd1, 1'b0, 1'b0, c);
         drive(1'b1, b2g(r + 3'd2), r + 3'd2, 1'b0, 1'b0, c);
         drive(1'b1, b2g(r + 3'd3), r + 3'd3, 1'b0, 1'b1, c);
         r = r + 3'd3;
      end
      gap();
      check("sat_err_count", 32'(err_count), 32'd255);
      check("sat_locked", 32'(locked), 32'd1);

      // Mid-lock reset for one cycle
      do_reset(1);

      // After reset: fresh acquisition from 000
      drive(1'b1, 3'b000, 3'd0, 1'b0, 1'b0, 8'd0);
      drive(1'b1, 3'b001, 3'd1, 1'b0, 1'b0, 8'd0);
      drive(1'b1, 3'b011, 3'd2, 1'b0, 1'b1, 8'd0);
      gap(); gap();

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
